pcileech_tlp_tx_arbiter: RTL and testbench
==========================================

Name: pcileech_tlp_tx_arbiter

Overview:
- Shares the single PCIe core TLP transmit stream between several TLP sources, for example FIFO-originated host TLPs, shadow config-space completions and internal VMD/bridge responders.
- Grants one requester per packet using round-robin priority and holds the grant until that packet's last beat is accepted, so TLPs are never interleaved or truncated.
- Sits in the clk_pcie domain between the TLP sources and the PCIe core TX interface.

Parameters:
- NUM_REQ, 3, number of requesters; legal range 2..8.
- DATA_W, 128, TLP data beat width in bits.
- KEEP_W, 4, DWORD-keep width, equal to DATA_W/32.

Ports:
- clk  input  1  clk_pcie domain clock.
- rst  input  1  synchronous reset, active-high.
- link_up  input  1  PCIe link status; no new grant is issued while it is low.
- req_tdata  input  NUM_REQ*DATA_W  per-requester beat data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_tkeepdw  input  NUM_REQ*KEEP_W  per-requester DWORD keep.
- req_tlast  input  NUM_REQ  per-requester last-beat flag.
- req_tvalid  input  NUM_REQ  per-requester beat valid.
- req_tready  output  NUM_REQ  per-requester beat accept.
- out_tdata  output  DATA_W  beat data to the PCIe core.
- out_tkeepdw  output  KEEP_W  DWORD keep to the PCIe core.
- out_tlast  output  1  last-beat flag to the PCIe core.
- out_tvalid  output  1  beat valid to the PCIe core.
- out_tready  input  1  PCIe core accept.
- grant_id  output  $clog2(NUM_REQ)  index of the current or most recent grant.
- busy  output  1  high while a packet is in progress.
- pkt_cnt  output  16  count of completed packets, wraps at 16 bits.

Behaviour:
- Reset values:
  - state = IDLE; busy = 0; grant_id = 0; pkt_cnt = 0.
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
  - All req_tready = 0; out_tvalid = 0; out_tlast = 0; out_tdata = 0; out_tkeepdw = 0.
- A beat is transferred on a clk edge where out_tvalid && out_tready are both high.
- IDLE state:
  - All req_tready = 0; out_tvalid = 0.
  - If link_up = 1 and req_tvalid != 0, the arbiter picks the first set req_tvalid bit searching last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - It registers that index into grant_id, sets busy = 1 and moves to XFER.
  - Grant latency: 1 cycle from req_tvalid to the first possible beat.
- XFER state:
  - Combinational pass-through with zero latency: out_tdata, out_tkeepdw, out_tlast and out_tvalid equal requester grant_id's signals.
  - req_tready[grant_id] = out_tready; all other req_tready bits = 0.
  - While the granted requester drops tvalid mid-packet, the grant is held and out_tvalid = 0; there is no timeout.
  - On a transferred beat with tlast = 1: last_grant <= grant_id; pkt_cnt <= pkt_cnt+1; busy <= 0; return to IDLE.
  - The IDLE return costs one bubble cycle between packets; this is accepted.
- Link loss:
  - link_up falling during XFER does not abort the packet; it completes normally.
  - The next grant waits in IDLE until link_up = 1.
- Requester rules:
  - A requester must keep tvalid high once asserted until its beat is accepted.
  - The arbiter never samples a non-granted requester's data.
- Single-beat packets (tlast on the first beat) are legal: one beat, then IDLE.
- Fairness: with all NUM_REQ requesters continuously valid, grants cycle 0,1,...,NUM_REQ-1,0,...
  - No requester waits more than NUM_REQ-1 packets.
- Reset mid-packet: immediately IDLE, all outputs return to their reset values and last_grant = NUM_REQ-1.
  - The partial packet is discarded at the arbiter; the downstream core is reset by the same rst.
- pkt_cnt wraps from 16'hFFFF to 16'h0000.
- grant_id holds its value in IDLE; it is informational only.

Test Plan:
- Reset, link_up=1, only req 1 valid with a 3-beat packet and out_tready=1:
  - Required: first beat on out_* on cycle 2.
  - Required: beats appear on 3 consecutive cycles, out_tlast on the 3rd.
  - Required: grant_id=1, pkt_cnt=1, busy=0 afterwards.
- All 3 requesters continuously valid with 2-beat packets:
  - Required: grant order 0,1,2,0,1,2.
  - Required: exactly one idle cycle between packets; pkt_cnt=6 after 6 packets.
- Req 0 mid-packet, then out_tready low for 4 cycles while req 2 raises tvalid:
  - Required: out_* holds req 0's beat stable.
  - Required: req_tready[2]=0 throughout; req 2 is granted only after req 0's tlast is accepted.
- Granted requester drops tvalid for 5 cycles mid-packet:
  - Required: out_tvalid=0, grant held, busy=1.
  - Required: the packet resumes and completes with no beat loss or duplication, checked against a scoreboard.
- link_up deasserted on beat 2 of a 4-beat packet, with other requesters pending:
  - Required: all 4 beats complete.
  - Required: no new grant while link_up=0; a grant issues 1 cycle after link_up returns to 1.
- rst pulsed during beat 2 of a packet:
  - Required: next cycle out_tvalid=0, busy=0, pkt_cnt=0.
  - Required: a subsequent request from req 0 and req 1 together is granted to req 0 first.
  - Separately: force pkt_cnt to 16'hFFFF, complete one packet, and confirm pkt_cnt=0.

Source files
------------

// File: rtl/pcileech_tlp_tx_arbiter.sv
// Round-robin packet arbiter sharing the PCIe core TLP transmit stream.
// A grant is held from the first beat until the tlast beat is accepted.
module pcileech_tlp_tx_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 128,
    parameter int KEEP_W  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         link_up,
    input  logic [NUM_REQ*DATA_W-1:0]    req_tdata,
    input  logic [NUM_REQ*KEEP_W-1:0]    req_tkeepdw,
    input  logic [NUM_REQ-1:0]           req_tlast,
    input  logic [NUM_REQ-1:0]           req_tvalid,
    output logic [NUM_REQ-1:0]           req_tready,
    output logic [DATA_W-1:0]            out_tdata,
    output logic [KEEP_W-1:0]            out_tkeepdw,
    output logic                         out_tlast,
    output logic                         out_tvalid,
    input  logic                         out_tready,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic [15:0]                  pkt_cnt
);

    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic [GW-1:0]   pick, cand;
    logic            busy_q, busy_d;
    logic [15:0]     cnt_q, pkt_cnt_d;
    logic [DATA_W-1:0] sel_data;
    logic [KEEP_W-1:0] sel_keep;
    logic            sel_last, sel_valid;
    int              idx;

    // Descending scan so the nearest requester after last_q wins.
    always_comb begin
        pick = '0;
        cand = '0;
        idx  = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx  = (int'(last_q) + k) % NUM_REQ;
            cand = GW'(idx);
            if (req_tvalid[cand]) pick = cand;
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == grant_q) begin
                sel_data  = req_tdata[i*DATA_W +: DATA_W];
                sel_keep  = req_tkeepdw[i*KEEP_W +: KEEP_W];
                sel_last  = req_tlast[i];
                sel_valid = req_tvalid[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        busy_d      = busy_q;
        pkt_cnt_d   = cnt_q;
        req_tready  = '0;
        out_tdata   = '0;
        out_tkeepdw = '0;
        out_tlast   = 1'b0;
        out_tvalid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (link_up && (|req_tvalid)) begin
                    grant_d = pick;
                    busy_d  = 1'b1;
                    state_d = XFER;
                end
            end
            XFER: begin
                out_tdata   = sel_data;
                out_tkeepdw = sel_keep;
                out_tlast   = sel_last;
                out_tvalid  = sel_valid;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (GW'(i) == grant_q) req_tready[i] = out_tready;
                end
                if (sel_valid && out_tready && sel_last) begin
                    last_d    = grant_q;
                    pkt_cnt_d = cnt_q + 16'd1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_REQ - 1);
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            cnt_q   <= pkt_cnt_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = busy_q;
    assign pkt_cnt  = cnt_q;

endmodule

// File: tb/tb_pcileech_tlp_tx_arbiter.sv
// Directed bench for pcileech_tlp_tx_arbiter with modelled TLP sources.
// Expected beats, grants and counters are hand-derived per step.
module tb_pcileech_tlp_tx_arbiter;

    localparam int N  = 3;
    localparam int DW = 128;
    localparam int KW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              link_up;
    logic [N*DW-1:0]   req_tdata;
    logic [N*KW-1:0]   req_tkeepdw;
    logic [N-1:0]      req_tlast;
    logic [N-1:0]      req_tvalid;
    logic [N-1:0]      req_tready;
    logic [DW-1:0]     out_tdata;
    logic [KW-1:0]     out_tkeepdw;
    logic              out_tlast;
    logic              out_tvalid;
    logic              out_tready;
    logic [1:0]        grant_id;
    logic              busy;
    logic [15:0]       pkt_cnt;

    int tests = 0;
    int fails = 0;

    int rem[N];
    int plen[N];
    int pos[N];
    int seq[N];
    bit en[N];
    logic [DW-1:0] obs[$];

    always #5 clk = ~clk;

    pcileech_tlp_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .KEEP_W(KW)) dut (
        .clk(clk), .rst(rst), .link_up(link_up),
        .req_tdata(req_tdata), .req_tkeepdw(req_tkeepdw),
        .req_tlast(req_tlast), .req_tvalid(req_tvalid),
        .req_tready(req_tready),
        .out_tdata(out_tdata), .out_tkeepdw(out_tkeepdw),
        .out_tlast(out_tlast), .out_tvalid(out_tvalid),
        .out_tready(out_tready),
        .grant_id(grant_id), .busy(busy), .pkt_cnt(pkt_cnt)
    );

    function automatic logic [DW-1:0] beat(int i, int s);
        return {4{8'(i), 24'(s)}};
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_tvalid[i]            = en[i] && (rem[i] > 0);
            req_tdata[i*DW +: DW]    = beat(i, seq[i]);
            req_tkeepdw[i*KW +: KW]  = 4'(seq[i] + 1);
            req_tlast[i]             = (pos[i] == plen[i] - 1);
        end
    endtask

    task automatic tick();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = req_tvalid & req_tready;
        if (out_tvalid && out_tready) obs.push_back(out_tdata);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                seq[i] = seq[i] + 1;
                rem[i] = rem[i] - 1;
                pos[i] = req_tlast[i] ? 0 : pos[i] + 1;
            end
        end
        drive();
        #1;
    endtask

    task automatic chk(string tag, logic [DW-1:0] o, logic [DW-1:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic clear();
        for (int i = 0; i < N; i++) begin
            rem[i]  = 0;
            plen[i] = 1;
            pos[i]  = 0;
            seq[i]  = 0;
            en[i]   = 1'b1;
        end
        obs.delete();
        drive();
    endtask

    task automatic setp(int i, int npk, int len);
        rem[i]  = npk * len;
        plen[i] = len;
        pos[i]  = 0;
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += rem[i];
        return s;
    endfunction

    task automatic drain(string tag);
        int n = 0;
        while ((pending() > 0 || busy) && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 128'(n < 200), 128'(1));
    endtask

    initial begin
        logic [1:0] order[$];
        int  idle;
        bit  started;
        bit  prevb;

        rst        = 1'b1;
        link_up    = 1'b1;
        out_tready = 1'b1;
        clear();
        tick();
        tick();
        chk("rst_busy",   128'(busy), 128'(0));
        chk("rst_grant",  128'(grant_id), 128'(0));
        chk("rst_pkt",    128'(pkt_cnt), 128'(0));
        chk("rst_tvalid", 128'(out_tvalid), 128'(0));
        chk("rst_tdata",  out_tdata, 128'(0));
        chk("rst_tready", 128'(req_tready), 128'(0));
        rst = 1'b0;
        tick();

        // single 3-beat packet from requester 1
        setp(1, 1, 3);
        drive();
        #1;
        chk("t1_pre_valid", 128'(out_tvalid), 128'(0));
        tick();
        chk("t1_b0_valid", 128'(out_tvalid), 128'(1));
        chk("t1_b0_grant", 128'(grant_id), 128'(1));
        chk("t1_b0_data",  out_tdata, beat(1, 0));
        chk("t1_b0_keep",  128'(out_tkeepdw), 128'(1));
        chk("t1_b0_last",  128'(out_tlast), 128'(0));
        tick();
        chk("t1_b1_valid", 128'(out_tvalid), 128'(1));
        chk("t1_b1_data",  out_tdata, beat(1, 1));
        tick();
        chk("t1_b2_data",  out_tdata, beat(1, 2));
        chk("t1_b2_last",  128'(out_tlast), 128'(1));
        tick();
        chk("t1_end_busy",  128'(busy), 128'(0));
        chk("t1_end_pkt",   128'(pkt_cnt), 128'(1));
        chk("t1_end_grant", 128'(grant_id), 128'(1));
        chk("t1_nbeats",    128'(obs.size()), 128'(3));

        // fairness: all requesters, two 2-beat packets each
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear();
        setp(0, 2, 2);
        setp(1, 2, 2);
        setp(2, 2, 2);
        drive();
        idle    = 0;
        started = 1'b0;
        prevb   = 1'b0;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (busy && !prevb) order.push_back(grant_id);
            if (busy) started = 1'b1;
            else if (started && pkt_cnt != 16'd6) idle++;
            prevb = busy;
            if (pkt_cnt == 16'd6 && !busy) break;
        end
        chk("t2_pkt",    128'(pkt_cnt), 128'(6));
        chk("t2_idle",   128'(idle), 128'(5));
        chk("t2_ngrant", 128'(order.size()), 128'(6));
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t2_order%0d", i), 128'(order[i]), 128'(i % 3));
        end
        chk("t2_nbeats", 128'(obs.size()), 128'(12));
        chk("t2_beat2",  obs[2], beat(1, 0));
        chk("t2_beat11", obs[11], beat(2, 3));

        // backpressure on requester 0 while requester 2 waits
        clear();
        setp(0, 1, 3);
        drive();
        tick();
        chk("t3_grant0", 128'(grant_id), 128'(0));
        tick();
        out_tready = 1'b0;
        setp(2, 1, 2);
        drive();
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("t3_hold_data",   out_tdata, beat(0, 1));
            chk("t3_hold_valid",  128'(out_tvalid), 128'(1));
            chk("t3_req2_tready", 128'(req_tready[2]), 128'(0));
            chk("t3_hold_grant",  128'(grant_id), 128'(0));
        end
        out_tready = 1'b1;
        tick();
        chk("t3_b2_data", out_tdata, beat(0, 2));
        tick();
        chk("t3_gap_busy", 128'(busy), 128'(0));
        tick();
        chk("t3_grant2", 128'(grant_id), 128'(2));
        chk("t3_r2_data", out_tdata, beat(2, 0));
        drain("t3_drain");
        chk("t3_nbeats", 128'(obs.size()), 128'(5));

        // granted requester stalls for 5 cycles mid-packet
        clear();
        setp(1, 1, 4);
        drive();
        tick();
        tick();
        en[1] = 1'b0;
        drive();
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("t4_stall_valid", 128'(out_tvalid), 128'(0));
            chk("t4_stall_busy",  128'(busy), 128'(1));
            chk("t4_stall_grant", 128'(grant_id), 128'(1));
        end
        en[1] = 1'b1;
        drive();
        drain("t4_drain");
        chk("t4_nbeats", 128'(obs.size()), 128'(4));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_sb%0d", i), obs[i], beat(1, i));
        end
        chk("t4_pkt", 128'(pkt_cnt), 128'(9));

        // link loss during a 4-beat packet with others pending
        clear();
        setp(2, 1, 4);
        setp(0, 1, 1);
        setp(1, 1, 1);
        drive();
        tick();
        chk("t5_grant2", 128'(grant_id), 128'(2));
        tick();
        link_up = 1'b0;
        tick();
        tick();
        tick();
        chk("t5_done_busy", 128'(busy), 128'(0));
        chk("t5_nbeats",    128'(obs.size()), 128'(4));
        chk("t5_last_beat", obs[3], beat(2, 3));
        chk("t5_pkt",       128'(pkt_cnt), 128'(10));
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("t5_nogrant", 128'(busy), 128'(0));
        end
        link_up = 1'b1;
        tick();
        chk("t5_regrant_busy",  128'(busy), 128'(1));
        chk("t5_regrant_grant", 128'(grant_id), 128'(0));
        drain("t5_drain");
        chk("t5_pkt_end", 128'(pkt_cnt), 128'(12));

        // reset mid-packet
        clear();
        setp(1, 1, 3);
        drive();
        tick();
        chk("t6_grant1", 128'(grant_id), 128'(1));
        tick();
        rst = 1'b1;
        tick();
        chk("t6_tvalid", 128'(out_tvalid), 128'(0));
        chk("t6_busy",   128'(busy), 128'(0));
        chk("t6_pkt",    128'(pkt_cnt), 128'(0));
        chk("t6_grant",  128'(grant_id), 128'(0));
        chk("t6_tready", 128'(req_tready), 128'(0));
        clear();
        rst = 1'b0;
        tick();
        setp(0, 1, 1);
        setp(1, 1, 1);
        drive();
        tick();
        chk("t6_first0", 128'(grant_id), 128'(0));
        drain("t6_drain");
        chk("t6_pkt2",   128'(pkt_cnt), 128'(2));
        chk("t6_beat1",  obs[1], beat(1, 0));

        // pkt_cnt wrap
        clear();
        force dut.pkt_cnt_d = 16'hFFFF;
        tick();
        release dut.pkt_cnt_d;
        #1;
        chk("t7_preset", 128'(pkt_cnt), 128'(16'hFFFF));
        setp(0, 1, 1);
        drive();
        tick();
        tick();
        chk("t7_wrap", 128'(pkt_cnt), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
